// File: rtl/pll_supervisor_pkg.sv
// Shared types and sizing helpers for the PLL supervisor.
package pll_supervisor_pkg;

    // Supervisor sequencing states; explicit encodings keep them stable for debug probes.
    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    // Width of a counter that must hold values 0 .. n-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Largest of three terminal counts, so one counter can serve every timed state.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_nco_ch.sv
// Single-channel phase accumulator producing a registered carry strobe.
module pll_nco_ch #(
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic             ce
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ce_q, ce_d;
    logic [ACC_W:0]   sum;

    // Accumulate while enabled; otherwise hold the phase at zero so restarts are deterministic.
    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, inc};
        if (en) begin
            acc_d = sum[ACC_W-1:0];
            ce_d  = sum[ACC_W];
        end else begin
            acc_d = '0;
            ce_d  = 1'b0;
        end
    end

    // Phase and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL reset sequencer, lock qualifier and fractional clock-enable generator (refclk domain).
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned ACC_W        = 24,
    parameter int unsigned RST_CYC      = 16,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned RETRY_MAX    = 3
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic                    restart,
    input  logic [NUM_CH*ACC_W-1:0] inc,
    output logic                    pll_rst,
    output logic                    ready,
    output logic                    fail,
    output logic [NUM_CH-1:0]       ce,
    output logic [7:0]              lock_loss_cnt
);

    localparam int unsigned CNT_W = cnt_w(max3(RST_CYC, LOCK_STABLE, LOCK_TIMEOUT));
    localparam int unsigned RTY_W = cnt_w(RETRY_MAX + 1);

    logic             lock_m_q, lock_s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             pll_rst_q, pll_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             run_en;

    // Two-flop synchroniser for the asynchronous lock indication.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m_q <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            lock_m_q <= pll_locked;
            lock_s_q <= lock_m_q;
        end
    end

    // Sequencing: reset pulse, lock wait with timeout/retry, stability window, run, latched failure.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (restart) begin
            state_d = ST_RESET;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(RST_CYC - 1)) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (lock_s_q) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = (retry_d >= RTY_W'(RETRY_MAX)) ? ST_FAIL : ST_RESET;
                    end
                end
                ST_STABLE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (!lock_s_q) begin
                        state_d = ST_RESET;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        state_d = ST_RESET;
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    end
                end
                ST_FAIL: ;
                default: state_d = ST_RESET;
            endcase
        end
        // Every state entry (and a restart while already in RESET) starts a fresh count.
        if (restart || (state_d != state_q)) cnt_d = '0;
        pll_rst_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    // State, counters and registered state-decoded outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    // Accumulate only while RUN persists: the first RUN cycle leaves phases at zero, and a
    // lock drop clears strobes on the same edge that deasserts ready.
    assign run_en = (state_q == ST_RUN) && (state_d == ST_RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pll_nco_ch #(.ACC_W(ACC_W)) u_nco (
            .clk   (refclk),
            .rst_n (rst_n),
            .en    (run_en),
            .inc   (inc[i*ACC_W +: ACC_W]),
            .ce    (ce[i])
        );
    end

    assign pll_rst       = pll_rst_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Self-checking bench for pll_supervisor: directed tables/sequences plus a cycle reference model.
module tb_pll_supervisor;

    localparam int unsigned NUM_CH = 2, ACC_W = 8;
    localparam int unsigned RST_CYC = 16, LOCK_STABLE = 256, LOCK_TIMEOUT = 64, RETRY_MAX = 3;
    localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;

    logic        refclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pll_locked = 1'b1, restart = 1'b0;
    logic [15:0] inc = '0;
    logic        pll_rst, ready, fail;
    logic [1:0]  ce;
    logic [7:0]  lock_loss_cnt;

    // Second instance with short windows, used for the saturation run.
    logic        pll_locked_s = 1'b1, restart_s = 1'b0;
    logic [15:0] inc_s = '0;
    logic        pll_rst_s, ready_s, fail_s;
    logic [1:0]  ce_s;
    logic [7:0]  loss_s;

    int checks = 0, errors = 0;

    pll_supervisor #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .RST_CYC(RST_CYC), .LOCK_STABLE(LOCK_STABLE),
                     .LOCK_TIMEOUT(LOCK_TIMEOUT), .RETRY_MAX(RETRY_MAX)) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart), .inc(inc),
        .pll_rst(pll_rst), .ready(ready), .fail(fail), .ce(ce), .lock_loss_cnt(lock_loss_cnt));

    pll_supervisor #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .RST_CYC(2), .LOCK_STABLE(4),
                     .LOCK_TIMEOUT(LOCK_TIMEOUT), .RETRY_MAX(RETRY_MAX)) dut_s (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked_s), .restart(restart_s), .inc(inc_s),
        .pll_rst(pll_rst_s), .ready(ready_s), .fail(fail_s), .ce(ce_s), .lock_loss_cnt(loss_s));

    initial forever #5 refclk = ~refclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge refclk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 2000) begin
            cyc(1);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready still %0d after %0d cycles", ready, n);
        end
    endtask

    // ---------------- reference model of the main instance ----------------
    int        m_ph = P_RESET, m_t = 0, m_retry = 0, m_loss = 0;
    bit        m_s1 = 0, m_s2 = 0;
    int        m_acc [NUM_CH];
    bit [1:0]  m_ce = '0;

    always @(posedge refclk or negedge rst_n) begin : model
        int nph, sum;
        bit ls;
        if (!rst_n) begin
            m_ph = P_RESET; m_t = 0; m_retry = 0; m_loss = 0;
            m_s1 = 0; m_s2 = 0; m_ce = '0;
            for (int c = 0; c < NUM_CH; c++) m_acc[c] = 0;
        end else begin
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_locked;
            nph  = m_ph;
            if (restart) begin
                nph = P_RESET;
                m_retry = 0;
            end else begin
                case (m_ph)
                    P_RESET:  if (m_t + 1 == RST_CYC) nph = P_WAIT;
                    P_WAIT: begin
                        if (ls) nph = P_STABLE;
                        else if (m_t + 1 == LOCK_TIMEOUT) begin
                            m_retry++;
                            nph = (m_retry >= RETRY_MAX) ? P_FAIL : P_RESET;
                        end
                    end
                    P_STABLE: begin
                        if (!ls) nph = P_RESET;
                        else if (m_t + 1 == LOCK_STABLE) begin
                            nph = P_RUN;
                            m_retry = 0;
                        end
                    end
                    P_RUN: if (!ls) begin
                        nph = P_RESET;
                        if (m_loss < 255) m_loss++;
                    end
                    default: ;
                endcase
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_ph == P_RUN && nph == P_RUN) begin
                    sum = m_acc[c] + int'(inc[c*ACC_W +: ACC_W]);
                    m_ce[c] = (sum >= (1 << ACC_W));
                    m_acc[c] = sum % (1 << ACC_W);
                end else begin
                    m_ce[c] = 1'b0;
                    m_acc[c] = 0;
                end
            end
            m_t  = (restart || nph != m_ph) ? 0 : m_t + 1;
            m_ph = nph;
        end
    end

    // Continuous comparison of the main instance against the model.
    always @(negedge refclk) begin : model_cmp
        bit e_rst, e_rdy, e_fail;
        e_rst  = (m_ph == P_RESET) || (m_ph == P_FAIL);
        e_rdy  = (m_ph == P_RUN);
        e_fail = (m_ph == P_FAIL);
        checks++;
        if (pll_rst !== e_rst || ready !== e_rdy || fail !== e_fail || ce !== m_ce ||
            lock_loss_cnt !== 8'(m_loss)) begin
            errors++;
            $display("FAIL model_cmp t=%0t: got rst=%0d rdy=%0d fail=%0d ce=%b loss=%0d expected rst=%0d rdy=%0d fail=%0d ce=%b loss=%0d",
                     $time, pll_rst, ready, fail, ce, lock_loss_cnt, e_rst, e_rdy, e_fail, m_ce, m_loss);
        end
    end

    // ---------------- directed and random stimulus ----------------
    typedef struct {
        logic [7:0] inc0;
        logic [7:0] inc1;
        int cnt0;
        int cnt1;
        int first0;
        int first1;
    } nco_vec_t;

    nco_vec_t tbl [3];

    initial begin : main
        int n, t, pulses, c0, c1, f0, f1, rdy_seen;
        bit prev;

        // Counts are carries in 16 cycles after ready (floor(inc*16/256)); first = cycle of first carry.
        tbl[0] = '{8'd128, 8'd64,  8,  4, 2, 4};
        tbl[1] = '{8'd0,   8'd255, 0, 15, 0, 2};
        tbl[2] = '{8'd96,  8'd200, 6, 12, 3, 2};

        #2 rst_n = 1'b0;
        @(negedge refclk);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_fail", fail, 0);
        check("rst_ce", ce, 0);
        check("rst_loss", lock_loss_cnt, 0);

        // Power-up with lock already present: RST_CYC reset, one WAIT_LOCK cycle, LOCK_STABLE window.
        rst_n = 1'b1;
        n = 0; t = 0;
        while (!ready && t < 1000) begin
            if (pll_rst) n++;
            cyc(1);
            t++;
        end
        check("powerup_pll_rst_width", n, RST_CYC);
        check("powerup_ready_latency", t, RST_CYC + 1 + LOCK_STABLE);

        // NCO strobe table.
        for (int r = 0; r < 3; r++) begin
            inc = {tbl[r].inc1, tbl[r].inc0};
            restart = 1'b1; cyc(1); restart = 1'b0;
            wait_ready(n);
            c0 = 0; c1 = 0; f0 = 0; f1 = 0;
            for (int j = 1; j <= 16; j++) begin
                cyc(1);
                if (ce[0]) begin c0++; if (f0 == 0) f0 = j; end
                if (ce[1]) begin c1++; if (f1 == 0) f1 = j; end
            end
            check($sformatf("nco%0d_cnt0", r), c0, tbl[r].cnt0);
            check($sformatf("nco%0d_cnt1", r), c1, tbl[r].cnt1);
            check($sformatf("nco%0d_first0", r), f0, tbl[r].first0);
            check($sformatf("nco%0d_first1", r), f1, tbl[r].first1);
        end

        // One-cycle lock drop in RUN.
        check("pre_drop_loss", lock_loss_cnt, 0);
        pll_locked = 1'b0; cyc(1); pll_locked = 1'b1;
        t = 0;
        while (ready && t < 10) begin cyc(1); t++; end
        check("drop_ready_fall", t, 2);
        check("drop_pll_rst", pll_rst, 1);
        check("drop_ce", ce, 0);
        check("drop_loss", lock_loss_cnt, 1);
        n = 0;
        while (pll_rst && n < 100) begin n++; cyc(1); end
        check("drop_pll_rst_width", n, RST_CYC);
        wait_ready(n);
        check("drop_relock_latency", n, LOCK_STABLE + 1);

        // lock_s low for STABLE cycle 100.
        restart = 1'b1; cyc(1); restart = 1'b0;
        rdy_seen = 0;
        for (int j = 0; j < 114; j++) begin cyc(1); if (ready) rdy_seen = 1; end
        pll_locked = 1'b0; cyc(1); pll_locked = 1'b1;
        for (int j = 0; j < 2; j++) begin cyc(1); if (ready) rdy_seen = 1; end
        check("glitch_ready_seen", rdy_seen, 0);
        check("glitch_back_to_reset", pll_rst, 1);
        check("glitch_loss", lock_loss_cnt, 1);
        wait_ready(n);
        check("glitch_relock_latency", n, RST_CYC + 1 + LOCK_STABLE);

        // Lock never arrives: retries then FAIL, restart clears retries.
        pll_locked = 1'b0;
        restart = 1'b1; cyc(1); restart = 1'b0;
        prev = pll_rst; pulses = 1; t = 0;
        while (!fail && t < 1000) begin
            cyc(1); t++;
            if (pll_rst && !prev && !fail) pulses++;
            prev = pll_rst;
        end
        check("fail_latency", t, RETRY_MAX * (RST_CYC + LOCK_TIMEOUT));
        check("fail_reset_pulses", pulses, RETRY_MAX);
        cyc(50);
        check("fail_held", fail, 1);
        check("fail_pll_rst_held", pll_rst, 1);
        restart = 1'b1; cyc(1); restart = 1'b0;
        check("restart_fail_clear", fail, 0);
        check("restart_pll_rst", pll_rst, 1);
        t = 0;
        while (!fail && t < 1000) begin cyc(1); t++; end
        check("refail_latency", t, RETRY_MAX * (RST_CYC + LOCK_TIMEOUT));
        pll_locked = 1'b1;
        restart = 1'b1; cyc(1); restart = 1'b0;
        wait_ready(n);

        // Randomised lock behaviour, restarts and increments against the model.
        n = 1;
        for (int i = 0; i < 20000; i++) begin
            n--;
            if (n <= 0) begin
                pll_locked = ~pll_locked;
                if (pll_locked) n = $urandom_range(700, 1);
                else if ($urandom_range(7, 0) == 0) n = $urandom_range(300, 60);
                else n = $urandom_range(40, 1);
            end
            inc = 16'($urandom);
            if ($urandom_range(3, 0) == 0) inc[7:0] = '0;
            restart = ($urandom_range(499, 0) == 0);
            cyc(1);
        end
        restart = 1'b0;

        // Saturation of the lock-loss counter on the short-window instance.
        for (int d = 1; d <= 300; d++) begin
            pll_locked_s = 1'b0; cyc(1); pll_locked_s = 1'b1;
            t = 0;
            while (ready_s && t < 20) begin cyc(1); t++; end
            t = 0;
            while (!ready_s && t < 200) begin cyc(1); t++; end
            if (!ready_s) begin
                checks++; errors++;
                $display("FAIL sat_relock_timeout: ready_s %0d at drop %0d", ready_s, d);
            end
            if (d == 1)   check("sat_loss_1", loss_s, 1);
            if (d == 254) check("sat_loss_254", loss_s, 254);
            if (d == 255) check("sat_loss_255", loss_s, 255);
        end
        check("sat_loss_300", loss_s, 255);

        // Asynchronous reset in the middle of RUN.
        pll_locked = 1'b1;
        inc = {8'd64, 8'd128};
        restart = 1'b1; cyc(1); restart = 1'b0;
        wait_ready(n);
        cyc(5);
        @(posedge refclk);
        #2 rst_n = 1'b0;
        #1;
        check("async_pll_rst", pll_rst, 1);
        check("async_ready", ready, 0);
        check("async_fail", fail, 0);
        check("async_ce", ce, 0);
        check("async_loss", lock_loss_cnt, 0);
        check("async_acc0", dut.g_ch[0].u_nco.acc_q, 0);
        check("async_acc1", dut.g_ch[1].u_nco.acc_q, 0);
        @(negedge refclk);
        rst_n = 1'b1;
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Parametrised PLL supervisor and clock-enable generator in the `refclk` domain, placed beside the PLL wrapper at the top of the design. It drives the PLL reset with a guaranteed minimum pulse and qualifies `locked` with a stability window. It retries on lock timeout, latches a hard failure after repeated timeouts, and counts lock-loss events. Once lock is stable it produces `NUM_CH` independent fractional clock-enable strobes from per-channel phase accumulators.

## Interface
- `NUM_CH`, 2: number of clock-enable channels (1..8).
- `ACC_W`, 24: phase accumulator width per channel.
- `RST_CYC`, 16: PLL reset pulse length in cycles (≥1).
- `LOCK_STABLE`, 256: consecutive synced-locked cycles required before RUN (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before a retry.
- `RETRY_MAX`, 3: timeouts tolerated before FAIL (≥1).

- `refclk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock, asynchronous; 2-flop synchronised internally (`lock_s`).
- `restart` in 1: single-cycle request to restart the sequence from any state.
- `inc` in NUM_CH*ACC_W: channel i increment at bits [i*ACC_W +: ACC_W], sampled every cycle.
- `pll_rst` out 1: active-high reset to PLL.
- `ready` out 1: high only in RUN.
- `fail` out 1: high only in FAIL.
- `ce` out NUM_CH: per-channel single-cycle enable strobes.
- `lock_loss_cnt` out 8: saturating count of lock drops seen in RUN.

## Operation
- States: RESET, WAIT_LOCK, STABLE, RUN, FAIL.
- Outputs are registered and decoded from state: `pll_rst`=1 in RESET and FAIL; `ready`=1 in RUN; `fail`=1 in FAIL.
- RESET: hold for exactly RST_CYC cycles, then go to WAIT_LOCK. The cycle counter clears on entry.
- WAIT_LOCK:
  - `lock_s`=1 → STABLE.
  - Otherwise, after LOCK_TIMEOUT cycles: `retry`+1. If `retry` reaches RETRY_MAX → FAIL, else → RESET.
- STABLE:
  - `lock_s`=0 → RESET. No retry increment.
  - LOCK_STABLE consecutive cycles with `lock_s`=1 → RUN. `retry` clears.
- RUN:
  - `lock_s`=0 → RESET.
  - `lock_loss_cnt`+1, saturating at 255. It is cleared only by `rst_n`.
- FAIL: held until `restart`.
- `restart` in any state → RESET, `retry`=0. It takes priority over every other transition in the same cycle.
- NCO, per channel:
  - In RUN: `{carry, acc} = acc + inc_i`, and `ce_i` is set to `carry`.
  - Outside RUN: `acc`=0 and `ce_i`=0.
  - `inc_i`=0 → `ce_i` never asserts.
  - Strobe rate is `inc_i`/2^ACC_W of `refclk`. Wrap-around is modulo 2^ACC_W.

## Timing
- Reset values: state RESET, `pll_rst`=1, `ready`=0, `fail`=0, `ce`=0, `lock_loss_cnt`=0, `retry`=0, all accumulators 0.
- `rst_n` assertion mid-operation forces these values immediately (asynchronous). Release is synchronous to the next `refclk` edge.
- `pll_locked` to `lock_s` latency: 2 cycles.
- `ready` rises on the cycle after the LOCK_STABLE-th consecutive `lock_s`=1 cycle in STABLE.
- `ready` falls, `pll_rst` rises, and all `ce` drop on the cycle after `lock_s` falls in RUN. No `ce` strobe occurs after `ready`=0.
- With `inc_i`=2^(ACC_W-1): first `ce_i` pulse occurs 2 cycles after `ready` rises, then every 2 cycles.
- `pll_rst` pulse width is always exactly RST_CYC cycles. Exception: `restart` during RESET restarts the count.

## Structure
- Package `pll_supervisor_pkg`: the state enum and the `$clog2`-based counter width functions.
- One sub-module, `pll_nco_ch`: a single-channel accumulator with carry-registered `ce`, instantiated NUM_CH times in a generate loop.
- The FSM, counters, and synchroniser live in the top module.

## Test plan
- Release `rst_n` with `pll_locked`=1 (RST_CYC=16, LOCK_STABLE=256) → `pll_rst` high 16 cycles; `ready` rises 16+2+256 (+1 register) cycles after release, ±1 for synchroniser alignment; bench checks the exact count.
- `pll_locked` held 0, LOCK_TIMEOUT=64, RETRY_MAX=3 → three RESET pulses, then `fail`=1 and `pll_rst`=1 held. A `restart` pulse then gives a fresh RESET with `retry`=0.
- In RUN, drop `pll_locked` for 1 cycle → `ready` falls, `lock_loss_cnt`=1, a full RST_CYC pulse follows, and the sequence re-locks. After 300 drops `lock_loss_cnt`=255.
- `lock_s` glitches low at cycle 100 of STABLE → back to RESET, `retry` unchanged, `ready` never rises.
- NUM_CH=2, ACC_W=8, `inc`={8'd64, 8'd128} → `ce[0]` every 2 cycles and `ce[1]` every 4 cycles, with the first pulses 2 and 4 cycles after `ready`. `inc`=0 on a channel gives no strobes.
- Assert `rst_n` asynchronously mid-RUN → all outputs reach reset values before the next edge, and accumulators read 0.
